// File: rtl/riscv_pkg.sv
// -----------------------------------------------------------------------------
// riscv_pkg
// Shared definitions for the RISC-V core front end:
//   XLEN                 - architectural register / address width
//   INSTR_ALIGN_MASK     - low PC bits that must be zero for a legal fetch
//   RESET_VECTOR_DEFAULT - default boot PC
//   fetch_state_e        - fetch sequencer state encoding
//   is_word_aligned()    - alignment test on the low address bits
// -----------------------------------------------------------------------------
package riscv_pkg;

    localparam int               XLEN                 = 32;
    localparam logic [1:0]       INSTR_ALIGN_MASK     = 2'b11;
    localparam logic [XLEN-1:0]  RESET_VECTOR_DEFAULT = 32'h0000_0000;

    typedef enum logic [2:0] {
        FETCH_IDLE  = 3'd0,
        FETCH_REQ   = 3'd1,
        FETCH_WAIT  = 3'd2,
        FETCH_OUT   = 3'd3,
        FETCH_FAULT = 3'd4
    } fetch_state_e;

    // Only the two low address bits decide word alignment.
    function automatic logic is_word_aligned(input logic [1:0] addr_lsb);
        return ((addr_lsb & INSTR_ALIGN_MASK) == 2'b00);
    endfunction

endpackage

// File: rtl/pc_fetch_sequencer.sv
// -----------------------------------------------------------------------------
// pc_fetch_sequencer
// Program counter register and instruction-fetch sequencer.
//
// Holds PC_Current (fed to the external PC+4 adder, whose result comes back on
// PC_Next_Seq), issues one word read at a time to instruction memory over a
// valid/ready request channel, captures the response, and offers it with its
// PC to decode over a valid/ready handshake. Handles branch/jump redirects,
// issue stall, and faults on misaligned redirect targets.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   PC_Next_Seq       sequential next PC (PC_Current + 4) from the adder
//   Redirect_Valid    one-cycle redirect strobe
//   Redirect_Target   redirect destination
//   Stall             holds off issue of a new fetch (IDLE -> REQ only)
//   PC_Current        PC being fetched or held
//   Imem_Req_Valid    fetch request valid
//   Imem_Req_Addr     fetch word address (mirrors PC_Current)
//   Imem_Req_Ready    memory accepts the request
//   Imem_Rsp_Valid    read data valid
//   Imem_Rsp_Data     read data
//   Instr_Valid       instruction available to decode
//   Instr             held instruction
//   Instr_PC          PC of the held instruction
//   Instr_Ready       decode accepts the instruction
//   Misalign_Fault    sticky flag, set by a redirect to a non-word target
// -----------------------------------------------------------------------------
module pc_fetch_sequencer
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_VECTOR = RESET_VECTOR_DEFAULT
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [XLEN-1:0] PC_Next_Seq,
    input  logic            Redirect_Valid,
    input  logic [XLEN-1:0] Redirect_Target,
    input  logic            Stall,
    output logic [XLEN-1:0] PC_Current,
    output logic            Imem_Req_Valid,
    output logic [XLEN-1:0] Imem_Req_Addr,
    input  logic            Imem_Req_Ready,
    input  logic            Imem_Rsp_Valid,
    input  logic [XLEN-1:0] Imem_Rsp_Data,
    output logic            Instr_Valid,
    output logic [XLEN-1:0] Instr,
    output logic [XLEN-1:0] Instr_PC,
    input  logic            Instr_Ready,
    output logic            Misalign_Fault
);

    fetch_state_e    state_r;
    logic [XLEN-1:0] pc_r;
    logic [XLEN-1:0] instr_r;
    logic [XLEN-1:0] instr_pc_r;
    logic            req_valid_r;
    logic            instr_valid_r;
    logic            fault_r;
    // kill_r marks the in-flight fetch as stale: its response is dropped.
    logic            kill_r;
    // A redirect seen while a request is still waiting for ready is parked
    // here, because the request address must not move before acceptance.
    logic            pend_valid_r;
    logic [XLEN-1:0] pend_target_r;

    logic            redirect_ok_s;
    logic            redirect_bad_s;

    // Split an incoming redirect into legal (word aligned) and faulting.
    always_comb begin
        redirect_ok_s  = 1'b0;
        redirect_bad_s = 1'b0;
        if (Redirect_Valid) begin
            if (is_word_aligned(Redirect_Target[1:0])) begin
                redirect_ok_s = 1'b1;
            end else begin
                redirect_bad_s = 1'b1;
            end
        end else begin
            redirect_ok_s  = 1'b0;
            redirect_bad_s = 1'b0;
        end
    end

    // Fetch FSM: state, PC and all handshake outputs are registered here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= FETCH_IDLE;
            pc_r          <= RESET_VECTOR;
            instr_r       <= 32'h0000_0000;
            instr_pc_r    <= 32'h0000_0000;
            req_valid_r   <= 1'b0;
            instr_valid_r <= 1'b0;
            fault_r       <= 1'b0;
            kill_r        <= 1'b0;
            pend_valid_r  <= 1'b0;
            pend_target_r <= 32'h0000_0000;
        end else begin
            case (state_r)
                FETCH_IDLE: begin
                    if (redirect_bad_s) begin
                        state_r <= FETCH_FAULT;
                        fault_r <= 1'b1;
                    end else if (redirect_ok_s) begin
                        // Retarget before issuing; stay idle this cycle.
                        pc_r <= Redirect_Target;
                    end else if (!Stall) begin
                        state_r     <= FETCH_REQ;
                        req_valid_r <= 1'b1;
                    end
                end

                FETCH_REQ: begin
                    if (redirect_bad_s) begin
                        // The asserted request is allowed to finish in FAULT.
                        state_r      <= FETCH_FAULT;
                        fault_r      <= 1'b1;
                        pend_valid_r <= 1'b0;
                        if (Imem_Req_Ready) begin
                            req_valid_r <= 1'b0;
                        end
                    end else if (Imem_Req_Ready) begin
                        req_valid_r  <= 1'b0;
                        state_r      <= FETCH_WAIT;
                        pend_valid_r <= 1'b0;
                        // A redirect this cycle is newer than a parked one.
                        if (redirect_ok_s) begin
                            kill_r <= 1'b1;
                            pc_r   <= Redirect_Target;
                        end else if (pend_valid_r) begin
                            kill_r <= 1'b1;
                            pc_r   <= pend_target_r;
                        end
                    end else if (redirect_ok_s) begin
                        pend_valid_r  <= 1'b1;
                        pend_target_r <= Redirect_Target;
                    end
                end

                FETCH_WAIT: begin
                    if (redirect_bad_s) begin
                        state_r <= FETCH_FAULT;
                        fault_r <= 1'b1;
                        kill_r  <= 1'b0;
                    end else if (Imem_Rsp_Valid) begin
                        if (kill_r || redirect_ok_s) begin
                            // Stale data for a superseded PC: throw it away.
                            kill_r  <= 1'b0;
                            state_r <= FETCH_IDLE;
                            if (redirect_ok_s) begin
                                pc_r <= Redirect_Target;
                            end
                        end else begin
                            instr_r       <= Imem_Rsp_Data;
                            instr_pc_r    <= pc_r;
                            instr_valid_r <= 1'b1;
                            state_r       <= FETCH_OUT;
                        end
                    end else if (redirect_ok_s) begin
                        kill_r <= 1'b1;
                        pc_r   <= Redirect_Target;
                    end
                end

                FETCH_OUT: begin
                    if (redirect_bad_s) begin
                        state_r       <= FETCH_FAULT;
                        fault_r       <= 1'b1;
                        instr_valid_r <= 1'b0;
                    end else if (redirect_ok_s) begin
                        // Covers both drop and same-cycle handoff: the
                        // redirect target always wins over PC+4.
                        pc_r          <= Redirect_Target;
                        instr_valid_r <= 1'b0;
                        state_r       <= FETCH_IDLE;
                    end else if (Instr_Ready) begin
                        pc_r          <= PC_Next_Seq;
                        instr_valid_r <= 1'b0;
                        state_r       <= FETCH_IDLE;
                    end
                end

                FETCH_FAULT: begin
                    // Terminal until reset; only finish an asserted request.
                    if (req_valid_r && Imem_Req_Ready) begin
                        req_valid_r <= 1'b0;
                    end
                end

                default: begin
                    state_r       <= FETCH_IDLE;
                    req_valid_r   <= 1'b0;
                    instr_valid_r <= 1'b0;
                    kill_r        <= 1'b0;
                    pend_valid_r  <= 1'b0;
                end
            endcase
        end
    end

    assign PC_Current     = pc_r;
    assign Imem_Req_Addr  = pc_r;
    assign Imem_Req_Valid = req_valid_r;
    assign Instr_Valid    = instr_valid_r;
    assign Instr          = instr_r;
    assign Instr_PC       = instr_pc_r;
    assign Misalign_Fault = fault_r;

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// -----------------------------------------------------------------------------
// tb_pc_fetch_sequencer
// Scoreboard bench: directed scenarios plus a randomized sequential run.
// Expected request addresses and delivered instructions are pushed into
// queues when stimulus is issued; a monitor pops and compares on every
// request and decode handshake. Memory content is a pure function of address.
// -----------------------------------------------------------------------------
module tb_pc_fetch_sequencer;

    localparam logic [31:0] RV = 32'h0000_0100;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] data;
    } exp_instr_t;

    logic        clk;
    logic        rst_n;
    logic [31:0] PC_Next_Seq;
    logic        Redirect_Valid;
    logic [31:0] Redirect_Target;
    logic        Stall;
    logic [31:0] PC_Current;
    logic        Imem_Req_Valid;
    logic [31:0] Imem_Req_Addr;
    logic        Imem_Req_Ready;
    logic        Imem_Rsp_Valid;
    logic [31:0] Imem_Rsp_Data;
    logic        Instr_Valid;
    logic [31:0] Instr;
    logic [31:0] Instr_PC;
    logic        Instr_Ready;
    logic        Misalign_Fault;

    int          checks_total = 0;
    int          checks_pass  = 0;
    int          req_acc_cnt  = 0;
    int          instr_acc_cnt = 0;

    logic [31:0] exp_req_q[$];
    exp_instr_t  exp_instr_q[$];

    // memory / ready control
    bit          rnd_mode    = 1'b0;
    bit          req_rdy_ctl = 1'b1;
    bit          instr_rdy_ctl = 1'b1;
    bit          req_rdy_rnd = 1'b1;
    bit          instr_rdy_rnd = 1'b1;
    int          lat_min = 1;
    int          lat_max = 1;
    int          rsp_cnt = 0;
    logic [31:0] rsp_addr = 32'h0;

    assign PC_Next_Seq    = PC_Current + 32'd4;   // the external adder
    assign Imem_Req_Ready = rnd_mode ? req_rdy_rnd : req_rdy_ctl;
    assign Instr_Ready    = rnd_mode ? instr_rdy_rnd : instr_rdy_ctl;

    pc_fetch_sequencer #(.RESET_VECTOR(RV)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .PC_Next_Seq    (PC_Next_Seq),
        .Redirect_Valid (Redirect_Valid),
        .Redirect_Target(Redirect_Target),
        .Stall          (Stall),
        .PC_Current     (PC_Current),
        .Imem_Req_Valid (Imem_Req_Valid),
        .Imem_Req_Addr  (Imem_Req_Addr),
        .Imem_Req_Ready (Imem_Req_Ready),
        .Imem_Rsp_Valid (Imem_Rsp_Valid),
        .Imem_Rsp_Data  (Imem_Rsp_Data),
        .Instr_Valid    (Instr_Valid),
        .Instr          (Instr),
        .Instr_PC       (Instr_PC),
        .Instr_Ready    (Instr_Ready),
        .Misalign_Fault (Misalign_Fault)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        if (a == 32'h0000_0100) return 32'h0000_0013;
        return {a[15:0], ~a[15:0]};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks_total++;
        if (act === exp) checks_pass++;
        else $display("FAIL %s: got %h, required %h", name, act, exp);
    endtask

    task automatic push_req(input logic [31:0] a);
        exp_req_q.push_back(a);
    endtask

    task automatic push_instr(input logic [31:0] a);
        exp_instr_t e;
        e.pc   = a;
        e.data = mem_fn(a);
        exp_instr_q.push_back(e);
    endtask

    // Memory: accepts at most one request, answers after lat cycles.
    initial begin
        Imem_Rsp_Valid = 1'b0;
        Imem_Rsp_Data  = 32'h0;
        forever begin
            @(negedge clk);
            if (rst_n && Imem_Req_Valid && Imem_Req_Ready) begin
                rsp_addr = Imem_Req_Addr;
                rsp_cnt  = $urandom_range(lat_max, lat_min);
            end
            @(posedge clk);
            #1;
            Imem_Rsp_Valid = 1'b0;
            Imem_Rsp_Data  = $urandom;
            if (rsp_cnt > 0) begin
                rsp_cnt--;
                if (rsp_cnt == 0) begin
                    Imem_Rsp_Valid = 1'b1;
                    Imem_Rsp_Data  = mem_fn(rsp_addr);
                end
            end
            req_rdy_rnd   = ($urandom_range(99, 0) < 60);
            instr_rdy_rnd = ($urandom_range(99, 0) < 60);
        end
    end

    // Monitor: compare every handshake against the scoreboard queues.
    initial begin
        logic [31:0] ea;
        exp_instr_t  ei;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (Imem_Req_Valid && Imem_Req_Ready) begin
                    req_acc_cnt++;
                    if (exp_req_q.size() == 0) begin
                        checks_total++;
                        $display("FAIL req_unexpected: got addr %h, required no request", Imem_Req_Addr);
                    end else begin
                        ea = exp_req_q.pop_front();
                        check("req_addr", Imem_Req_Addr, ea);
                    end
                end
                if (Instr_Valid && Instr_Ready) begin
                    instr_acc_cnt++;
                    if (exp_instr_q.size() == 0) begin
                        checks_total++;
                        $display("FAIL instr_unexpected: got pc %h data %h, required none", Instr_PC, Instr);
                    end else begin
                        ei = exp_instr_q.pop_front();
                        check("instr_data", Instr, ei.data);
                        check("instr_pc", Instr_PC, ei.pc);
                    end
                end
            end
        end
    end

    task automatic wait_req_valid(input string name);
        bit seen = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(posedge clk); #1;
            if (Imem_Req_Valid) begin seen = 1'b1; break; end
        end
        check(name, {31'd0, seen}, 32'd1);
    endtask

    task automatic wait_instr_valid(input string name);
        bit seen = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(posedge clk); #1;
            if (Instr_Valid) begin seen = 1'b1; break; end
        end
        check(name, {31'd0, seen}, 32'd1);
    endtask

    task automatic wait_req_cnt(input string name, input int n);
        bit seen = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(posedge clk); #1;
            if (req_acc_cnt >= n) begin seen = 1'b1; break; end
        end
        check(name, {31'd0, seen}, 32'd1);
    endtask

    task automatic wait_instr_cnt(input string name, input int n);
        bit seen = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(posedge clk); #1;
            if (instr_acc_cnt >= n) begin seen = 1'b1; break; end
        end
        check(name, {31'd0, seen}, 32'd1);
    endtask

    initial begin
        int n0;
        int bad;
        int base_i;
        int base_r;
        bit done;

        rst_n = 1'b0;
        Stall = 1'b0;
        Redirect_Valid  = 1'b0;
        Redirect_Target = 32'h0;

        // ---- reset values and first fetch ----
        repeat (3) @(posedge clk);
        #1;
        check("rst_pc", PC_Current, RV);
        check("rst_req_valid", {31'd0, Imem_Req_Valid}, 32'd0);
        check("rst_instr_valid", {31'd0, Instr_Valid}, 32'd0);
        check("rst_instr", Instr, 32'h0);
        check("rst_instr_pc", Instr_PC, 32'h0);
        check("rst_fault", {31'd0, Misalign_Fault}, 32'd0);
        push_req(RV);
        push_instr(RV);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("first_req_valid", {31'd0, Imem_Req_Valid}, 32'd1);
        check("first_req_addr", Imem_Req_Addr, RV);
        Stall = 1'b1;
        wait_instr_cnt("t1_deliver", 1);
        check("t1_pc_after", PC_Current, 32'h0000_0104);

        // ---- backpressure on both channels ----
        req_rdy_ctl = 1'b0;
        instr_rdy_ctl = 1'b0;
        push_req(32'h0000_0104);
        push_instr(32'h0000_0104);
        Stall = 1'b0;
        wait_req_valid("t2_req");
        Stall = 1'b1;
        repeat (5) begin
            check("bp_req_valid", {31'd0, Imem_Req_Valid}, 32'd1);
            check("bp_req_addr", Imem_Req_Addr, 32'h0000_0104);
            @(posedge clk); #1;
        end
        req_rdy_ctl = 1'b1;
        wait_instr_valid("t2_instr");
        repeat (3) begin
            check("bp_instr_valid", {31'd0, Instr_Valid}, 32'd1);
            check("bp_instr", Instr, mem_fn(32'h0000_0104));
            check("bp_instr_pc", Instr_PC, 32'h0000_0104);
            @(posedge clk); #1;
        end
        instr_rdy_ctl = 1'b1;
        wait_instr_cnt("t2_deliver", 2);
        check("t2_pc_after", PC_Current, 32'h0000_0108);

        // ---- redirect while waiting for the response ----
        lat_min = 3; lat_max = 3;
        push_req(32'h0000_0108);
        push_req(32'h0000_0200);
        push_instr(32'h0000_0200);
        Stall = 1'b0;
        wait_req_cnt("t3_accept", 3);
        Redirect_Valid = 1'b1; Redirect_Target = 32'h0000_0200;
        @(posedge clk); #1;
        Redirect_Valid = 1'b0;
        check("wait_redir_pc", PC_Current, 32'h0000_0200);
        wait_req_valid("t3_req_new");
        Stall = 1'b1;
        wait_instr_cnt("t3_deliver", 3);
        check("t3_pc_after", PC_Current, 32'h0000_0204);
        lat_min = 1; lat_max = 1;

        // ---- redirect while the request is held off ----
        req_rdy_ctl = 1'b0;
        push_req(32'h0000_0204);
        push_req(32'h0000_0280);
        push_instr(32'h0000_0280);
        Stall = 1'b0;
        wait_req_valid("t3b_req");
        Redirect_Valid = 1'b1; Redirect_Target = 32'h0000_0280;
        @(posedge clk); #1;
        Redirect_Valid = 1'b0;
        check("req_redir_addr_stable", Imem_Req_Addr, 32'h0000_0204);
        check("req_redir_valid_stable", {31'd0, Imem_Req_Valid}, 32'd1);
        req_rdy_ctl = 1'b1;
        wait_req_cnt("t3b_accept", 5);
        wait_req_valid("t3b_req_new");
        Stall = 1'b1;
        wait_instr_cnt("t3b_deliver", 4);
        check("t3b_pc_after", PC_Current, 32'h0000_0284);

        // ---- redirect coinciding with handoff ----
        instr_rdy_ctl = 1'b0;
        push_req(32'h0000_0284);
        push_instr(32'h0000_0284);
        push_req(32'h0000_0300);
        push_instr(32'h0000_0300);
        n0 = instr_acc_cnt;
        Stall = 1'b0;
        wait_instr_valid("t4_instr");
        Redirect_Valid = 1'b1; Redirect_Target = 32'h0000_0300;
        instr_rdy_ctl = 1'b1;
        @(posedge clk); #1;
        Redirect_Valid = 1'b0;
        check("out_handoff_counted", instr_acc_cnt, n0 + 1);
        check("out_redir_pc", PC_Current, 32'h0000_0300);
        check("out_redir_drop", {31'd0, Instr_Valid}, 32'd0);
        wait_req_valid("t4_req_new");
        Stall = 1'b1;
        wait_instr_cnt("t4_deliver", n0 + 2);
        check("t4_pc_after", PC_Current, 32'h0000_0304);

        // ---- stall in IDLE, then asynchronous reset during WAIT ----
        bad = 0;
        repeat (5) begin
            @(posedge clk); #1;
            if (Imem_Req_Valid) bad++;
        end
        check("stall_no_req", bad, 0);
        lat_min = 3; lat_max = 3;
        push_req(32'h0000_0304);
        n0 = req_acc_cnt;
        Stall = 1'b0;
        wait_req_cnt("t5_accept", n0 + 1);
        Stall = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_pc", PC_Current, RV);
        check("async_rst_req_valid", {31'd0, Imem_Req_Valid}, 32'd0);
        check("async_rst_instr_valid", {31'd0, Instr_Valid}, 32'd0);
        check("async_rst_instr", Instr, 32'h0);
        check("async_rst_instr_pc", Instr_PC, 32'h0);
        check("async_rst_fault", {31'd0, Misalign_Fault}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        bad = 0;
        repeat (6) begin
            @(posedge clk); #1;
            if (Instr_Valid || Imem_Req_Valid) bad++;
        end
        check("late_rsp_ignored", bad, 0);
        lat_min = 1; lat_max = 1;

        // ---- misaligned redirect while a request is held ----
        req_rdy_ctl = 1'b0;
        push_req(RV);
        Stall = 1'b0;
        wait_req_valid("t6_req");
        Redirect_Valid = 1'b1; Redirect_Target = 32'h0000_0202;
        @(posedge clk); #1;
        Redirect_Valid = 1'b0;
        check("fault_set", {31'd0, Misalign_Fault}, 32'd1);
        check("fault_req_held", {31'd0, Imem_Req_Valid}, 32'd1);
        check("fault_req_addr", Imem_Req_Addr, RV);
        n0 = req_acc_cnt;
        req_rdy_ctl = 1'b1;
        @(posedge clk); #1;
        bad = 0;
        for (int i = 0; i < 14; i++) begin
            @(posedge clk); #1;
            if (Imem_Req_Valid || Instr_Valid) bad++;
            if (i == 4) begin
                Redirect_Valid = 1'b1; Redirect_Target = 32'h0000_0400;
            end else begin
                Redirect_Valid = 1'b0;
            end
        end
        check("fault_quiet", bad, 0);
        check("fault_sticky", {31'd0, Misalign_Fault}, 32'd1);
        check("fault_req_completed", req_acc_cnt, n0 + 1);
        Stall = 1'b1;
        rst_n = 1'b0;
        #1;
        check("fault_cleared_by_rst", {31'd0, Misalign_Fault}, 32'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;

        // ---- randomized sequential run ----
        for (int k = 0; k < 20; k++) begin
            push_req(RV + 32'(k * 4));
            push_instr(RV + 32'(k * 4));
        end
        base_i = instr_acc_cnt;
        base_r = req_acc_cnt;
        lat_min = 1; lat_max = 3;
        rnd_mode = 1'b1;
        rst_n = 1'b1;
        done = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #1;
            if (req_acc_cnt - base_r >= 20) Stall = 1'b1;
            else Stall = ($urandom_range(99, 0) < 30);
            if (instr_acc_cnt - base_i >= 20) begin done = 1'b1; break; end
        end
        check("rand_done", {31'd0, done}, 32'd1);
        repeat (5) @(posedge clk);
        #1;
        check("rand_req_q_empty", exp_req_q.size(), 0);
        check("rand_instr_q_empty", exp_instr_q.size(), 0);
        check("rand_pc_final", PC_Current, RV + 32'd80);

        $display("%0d/%0d checks passed", checks_pass, checks_total);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/pc_fetch_sequencer.md
# pc_fetch_sequencer

Program counter register and instruction-fetch sequencer for the RISC-V core on FPGA. It holds `PC_Current`, which feeds the PC+4 adder, and takes the sequential next PC back from that adder. It issues word reads to the instruction memory over a valid/ready request channel, captures the returned instruction, and presents it with its PC to decode over a valid/ready handshake. Branch and jump redirects, stall, and misaligned-target faults are handled here.

## Interface
Parameters:
- `RESET_VECTOR`, default 32'h0000_0000, PC loaded on reset; must be word-aligned.

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `PC_Next_Seq`  in  32  sequential next PC from the adder (`PC_Current`+4).
- `Redirect_Valid`  in  1  one-cycle redirect request from branch/jump resolution.
- `Redirect_Target`  in  32  redirect destination.
- `Stall`  in  1  blocks issue of a new fetch request.
- `PC_Current`  out  32  PC of the instruction currently being fetched or held.
- `Imem_Req_Valid`  out  1  fetch request valid.
- `Imem_Req_Addr`  out  32  fetch word address; always equals `PC_Current`.
- `Imem_Req_Ready`  in  1  memory accepts the request.
- `Imem_Rsp_Valid`  in  1  read data valid.
- `Imem_Rsp_Data`  in  32  read data.
- `Instr_Valid`  out  1  instruction available to decode.
- `Instr`  out  32  held instruction.
- `Instr_PC`  out  32  PC of the held instruction.
- `Instr_Ready`  in  1  decode accepts the instruction.
- `Misalign_Fault`  out  1  sticky fault flag; set on a redirect to a non-word-aligned target.

## Operation
- States: IDLE, REQ, WAIT, OUT, FAULT.
- **IDLE:** go to REQ when `Stall`=0.
- **REQ:** `Imem_Req_Valid`=1.
  - Address and valid stay stable until `Imem_Req_Ready`.
  - On accept, go to WAIT.
- **WAIT:** on `Imem_Rsp_Valid`, capture `Imem_Rsp_Data` into `Instr` and `PC_Current` into `Instr_PC`, then go to OUT.
  - If the kill flag is set, discard the data, clear the flag, and go to IDLE.
- **OUT:** `Instr_Valid`=1.
  - On `Instr_Ready`: `PC_Current` <= `PC_Next_Seq`, then go to IDLE.
- **Redirect with target[1:0]==0:**
  - In IDLE: `PC_Current` <= target; stay in IDLE.
  - In REQ: the pending request still completes, so the valid/ready rule is never broken. The kill flag is set and `PC_Current` <= target after accept.
  - In WAIT: set the kill flag; `PC_Current` <= target.
  - In OUT: drop the held instruction (`Instr_Valid` falls next cycle); `PC_Current` <= target; go to IDLE.
  - In OUT with `Instr_Ready` in the same cycle: the handoff completes, and the redirect wins the PC update (`PC_Current` <= target).
- **Redirect with target[1:0]!=0:** enter FAULT and set `Misalign_Fault`.
  - FAULT issues no requests; a pending request still completes its handshake.
  - Responses are ignored in FAULT.
  - FAULT is left only by reset.
- `Stall` only gates the IDLE→REQ transition. It never aborts an in-flight or asserted request.
- `Imem_Rsp_Valid` outside WAIT is ignored.
- Responses arrive in order, at most one outstanding.
- All address arithmetic is external. This block never computes +4.

## Timing
- Reset values: `PC_Current`=`RESET_VECTOR`, state IDLE, `Imem_Req_Valid`=0, `Instr_Valid`=0, `Instr`=0, `Instr_PC`=0, `Misalign_Fault`=0, kill flag=0.
- The first request is asserted in the cycle after the first rising edge following `rst_n` release, provided `Stall`=0.
- The response must come at least 1 cycle after the accepting edge. A same-cycle response is illegal.
- `Instr_Valid` rises the cycle after `Imem_Rsp_Valid`.
- With zero-wait memory and ready decode, throughput is one instruction per 4 cycles (IDLE, REQ, WAIT, OUT).
- `rst_n` assertion mid-operation immediately clears all state. Any outstanding memory response after reset is ignored, because the state is not WAIT.
- `Misalign_Fault` rises the cycle after the offending redirect.

## Structure
- Shared package `riscv_pkg`: state encoding typedef, `XLEN`=32, `INSTR_ALIGN_MASK`=2'b11, `RESET_VECTOR_DEFAULT`.
- Single module; no sub-module is needed. The PC+4 adder remains its own existing block, instantiated next to this one at core level.

## Test plan
- **Reset fetch:** `RESET_VECTOR`=0x100, memory ready=1 with 1-cycle latency returning 0x00000013. Expect request addr 0x100, then `Instr`=0x00000013 and `Instr_PC`=0x100, then `PC_Current`=0x104 after `Instr_Ready`.
- **Backpressure:** hold `Imem_Req_Ready`=0 for 5 cycles and `Instr_Ready`=0 for 3 cycles. Expect `Imem_Req_Addr`/valid stable throughout, and `Instr`/`Instr_PC` stable throughout.
- **Redirect in WAIT:** target 0x200. Expect the response for the old PC discarded, `Instr_Valid` never raised for it, and the next request addr 0x200.
- **Redirect with same-cycle handoff in OUT:** target 0x300. Expect the handoff counted, `PC_Current`=0x300 (not PC+4), and the next request addr 0x300.
- **Misaligned redirect:** target 0x202. Expect `Misalign_Fault`=1 the next cycle, no further `Imem_Req_Valid`, and clearing only by `rst_n`.
- **Stall and mid-operation reset:** `Stall`=1 in IDLE gives no request. Pulsing `rst_n` low during WAIT restores all reset values asynchronously, and a late `Imem_Rsp_Valid` is ignored.
